// File: rtl/fc7_class_scorer_pkg.sv
// Shared definitions for the layer-7 class scorer and its downstream consumers.
package fc7_class_scorer_pkg;

    localparam int unsigned CLASS_NUM = 10;

    localparam int SCORE_MAX = 127;
    localparam int SCORE_MIN = -128;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_CALC,
        ST_EMIT,
        ST_DONE
    } fc7_state_e;

endpackage

// File: rtl/fc7_sat_shift.sv
// Arithmetic right shift of a signed accumulator followed by saturation to int8.
module fc7_sat_shift
    import fc7_class_scorer_pkg::*;
#(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned SHIFT = 7
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [7:0]       score_c
);

    localparam logic signed [ACC_W-1:0] HI = ACC_W'(SCORE_MAX);
    localparam logic signed [ACC_W-1:0] LO = ACC_W'(SCORE_MIN);

    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        shifted = acc >>> SHIFT;
        if (shifted > HI) begin
            score_c = HI[7:0];
        end else if (shifted < LO) begin
            score_c = LO[7:0];
        end else begin
            score_c = shifted[7:0];
        end
    end

endmodule

// File: rtl/fc7_class_scorer.sv
// Layer-7 fully connected scorer: buffers one frame of int8 activations, then
// streams one saturated int8 score per class using external weight/bias ROMs.
module fc7_class_scorer
    import fc7_class_scorer_pkg::*;
#(
    parameter int unsigned IN_NUM = 64,
    parameter int unsigned SHIFT  = 7,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned WA_W   = $clog2(CLASS_NUM * IN_NUM)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [7:0]      layer_6_out,
    input  logic                   full_connect_6_ready,
    output logic [WA_W-1:0]        weight_addr,
    input  logic signed [7:0]      weight_data,
    output logic [3:0]             bias_addr,
    input  logic signed [15:0]     bias_data,
    output logic signed [7:0]      layer_7_out,
    output logic                   full_connect_7_ready,
    output logic                   full_connect_7_complete
);

    localparam int unsigned CNT_W = $clog2(IN_NUM + 1);
    localparam int unsigned IDX_W = (IN_NUM > 1) ? $clog2(IN_NUM) : 1;
    localparam int unsigned CLS_W = 4;

    fc7_state_e              state;
    fc7_state_e              state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        step;
    logic [CLS_W-1:0]        cls;
    logic signed [ACC_W-1:0] acc;
    logic signed [7:0]       act_buf [IN_NUM];

    logic signed [7:0]       act_sel_c;
    logic signed [15:0]      prod_c;
    logic signed [7:0]       score_c;
    logic                    load_last_c;
    logic                    calc_last_c;
    logic                    class_last_c;

    assign bias_addr = cls;

    // Step k of CALC consumes the weight addressed on step k-1.
    always_comb begin
        load_last_c  = full_connect_6_ready && (cnt == CNT_W'(IN_NUM - 1));
        calc_last_c  = (step == CNT_W'(IN_NUM));
        class_last_c = (cls == CLS_W'(CLASS_NUM - 1));
        act_sel_c    = act_buf[IDX_W'(step - CNT_W'(1))];
        prod_c       = act_sel_c * weight_data;
    end

    fc7_sat_shift #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_sat_shift (
        .acc     (acc),
        .score_c (score_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: if (load_last_c)  state_nxt = ST_CALC;
            ST_CALC: if (calc_last_c)  state_nxt = ST_EMIT;
            ST_EMIT: state_nxt = class_last_c ? ST_DONE : ST_CALC;
            ST_DONE: state_nxt = ST_LOAD;
            default: state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt                     <= '0;
            step                    <= '0;
            cls                     <= '0;
            acc                     <= '0;
            weight_addr             <= '0;
            layer_7_out             <= '0;
            full_connect_7_ready    <= 1'b0;
            full_connect_7_complete <= 1'b0;
            for (int i = 0; i < int'(IN_NUM); i++) begin
                act_buf[i] <= '0;
            end
        end else begin
            full_connect_7_ready    <= 1'b0;
            full_connect_7_complete <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (full_connect_6_ready) begin
                        act_buf[IDX_W'(cnt)] <= layer_6_out;
                        cnt                  <= cnt + CNT_W'(1);
                    end
                    if (load_last_c) begin
                        weight_addr <= '0;
                        step        <= '0;
                    end
                end
                ST_CALC: begin
                    step <= step + CNT_W'(1);
                    if (step < CNT_W'(IN_NUM - 1)) begin
                        weight_addr <= weight_addr + WA_W'(1);
                    end
                    if (step == CNT_W'(1)) begin
                        acc <= ACC_W'(bias_data) + ACC_W'(prod_c);
                    end else if (step != '0) begin
                        acc <= acc + ACC_W'(prod_c);
                    end
                end
                ST_EMIT: begin
                    layer_7_out          <= score_c;
                    full_connect_7_ready <= 1'b1;
                    step                 <= '0;
                    // Weight address already sits on the last weight of this class.
                    if (!class_last_c) begin
                        cls         <= cls + CLS_W'(1);
                        weight_addr <= weight_addr + WA_W'(1);
                    end
                end
                ST_DONE: begin
                    full_connect_7_complete <= 1'b1;
                    cnt                     <= '0;
                    cls                     <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fc7_class_scorer.sv
// Scoreboard bench for fc7_class_scorer: two instances (SHIFT=0 and SHIFT=7) share stimulus and ROM contents.
module tb_fc7_class_scorer;

    localparam int IN_NUM    = 4;
    localparam int CLASS_NUM = 10;
    localparam int WA_W      = 6;

    logic              clk;
    logic              rst;
    logic signed [7:0] l6;
    logic              l6_rdy;

    logic [WA_W-1:0]   wa0, wa7;
    logic [3:0]        ba0, ba7;
    logic signed [7:0] wd0, wd7;
    logic signed [15:0] bd0, bd7;
    logic [7:0]        l7_0, l7_7;
    logic              rdy0, rdy7, cmp0, cmp7;

    logic signed [7:0]  w_rom [64];
    logic signed [15:0] b_rom [16];

    int n_tests;
    int n_fail;
    int cyc;
    int first_exp;
    int rcnt;
    int last_ready;
    int q0[$];
    int q7[$];
    int xv[IN_NUM];

    fc7_class_scorer #(.IN_NUM(IN_NUM), .SHIFT(0), .ACC_W(24), .WA_W(WA_W)) u_dut0 (
        .clk                     (clk),
        .rst                     (rst),
        .layer_6_out             (l6),
        .full_connect_6_ready    (l6_rdy),
        .weight_addr             (wa0),
        .weight_data             (wd0),
        .bias_addr               (ba0),
        .bias_data               (bd0),
        .layer_7_out             (l7_0),
        .full_connect_7_ready    (rdy0),
        .full_connect_7_complete (cmp0)
    );

    fc7_class_scorer #(.IN_NUM(IN_NUM), .SHIFT(7), .ACC_W(24), .WA_W(WA_W)) u_dut7 (
        .clk                     (clk),
        .rst                     (rst),
        .layer_6_out             (l6),
        .full_connect_6_ready    (l6_rdy),
        .weight_addr             (wa7),
        .weight_data             (wd7),
        .bias_addr               (ba7),
        .bias_data               (bd7),
        .layer_7_out             (l7_7),
        .full_connect_7_ready    (rdy7),
        .full_connect_7_complete (cmp7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROMs with one cycle of read latency.
    always @(posedge clk) begin
        wd0 <= w_rom[wa0];
        bd0 <= b_rom[ba0];
        wd7 <= w_rom[wa7];
        bd7 <= b_rom[ba7];
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int sat8(input int v);
        if (v > 127)  return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic push_expect(input int x[IN_NUM]);
        int acc;
        for (int c = 0; c < CLASS_NUM; c++) begin
            acc = int'(b_rom[c]);
            for (int i = 0; i < IN_NUM; i++) begin
                acc += x[i] * int'(w_rom[c * IN_NUM + i]);
            end
            q0.push_back(sat8(acc) & 255);
            q7.push_back(sat8(acc >>> 7) & 255);
        end
    endtask

    // Called at a negedge; the first input is driven in that same cycle.
    task automatic load_frame(input int x[IN_NUM], input bit gaps);
        push_expect(x);
        for (int i = 0; i < IN_NUM; i++) begin
            if (i > 0) @(negedge clk);
            if (gaps && i == 2) begin
                l6_rdy = 1'b0;
                @(negedge clk);
            end
            l6     = 8'(x[i]);
            l6_rdy = 1'b1;
            if (i == IN_NUM - 1) first_exp = cyc + IN_NUM + 3;
        end
        @(negedge clk);
        l6_rdy = 1'b0;
    endtask

    task automatic wait_complete(input bit noise);
        bit done;
        done = 1'b0;
        for (int i = 1; i <= 200 && !done; i++) begin
            @(negedge clk);
            if (cmp0) begin
                done   = 1'b1;
                l6_rdy = 1'b0;
            end else if (noise && i >= 2 && i <= 50 && (i % 7) == 3) begin
                l6_rdy = 1'b1;
                l6     = 8'($urandom);
            end else begin
                l6_rdy = 1'b0;
            end
        end
        check("complete_seen", int'(done), 1);
    endtask

    task automatic set_roms_linear();
        for (int c = 0; c < CLASS_NUM; c++) begin
            b_rom[c] = '0;
            for (int i = 0; i < IN_NUM; i++) w_rom[c * IN_NUM + i] = 8'(c);
        end
    endtask

    // Scoreboard and timing checker for the SHIFT=0 instance.
    always @(negedge clk) begin
        int e;
        if (!rst) begin
            q0.delete();
            rcnt = 0;
            check("rst_score", int'(l7_0), 0);
            check("rst_ready", int'(rdy0), 0);
            check("rst_complete", int'(cmp0), 0);
        end else begin
            if (rdy0) begin
                if (q0.size() == 0) begin
                    check("spurious_ready", int'(rdy0), 0);
                end else begin
                    e = q0.pop_front();
                    check("score_s0", int'(l7_0), e);
                    if (rcnt == 0) check("first_ready_lat", cyc, first_exp);
                    else           check("ready_period", cyc - last_ready, IN_NUM + 2);
                end
                rcnt++;
                last_ready = cyc;
            end
            if (cmp0) begin
                check("complete_gap", cyc - last_ready, 1);
                check("ready_count", rcnt, CLASS_NUM);
                rcnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        int e;
        if (!rst) begin
            q7.delete();
        end else if (rdy7) begin
            if (q7.size() == 0) begin
                check("spurious_ready7", int'(rdy7), 0);
            end else begin
                e = q7.pop_front();
                check("score_s7", int'(l7_7), e);
            end
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        rcnt    = 0;
        last_ready = 0;
        first_exp  = 0;
        rst     = 1'b0;
        l6      = '0;
        l6_rdy  = 1'b0;
        for (int i = 0; i < 64; i++) w_rom[i] = '0;
        for (int i = 0; i < 16; i++) b_rom[i] = '0;

        repeat (3) @(negedge clk);
        check("reset_score7", int'(l7_7), 0);
        check("reset_ready7", int'(rdy7), 0);
        #2 rst = 1'b1;
        @(negedge clk);

        // Linear weights: class c scores 4*c.
        set_roms_linear();
        xv = '{1, 1, 1, 1};
        load_frame(xv, 1'b1);
        wait_complete(1'b0);

        // Saturation high and low, loaded back-to-back.
        for (int i = 0; i < 64; i++) w_rom[i] = 8'sd127;
        xv = '{127, 127, 127, 127};
        load_frame(xv, 1'b0);
        wait_complete(1'b0);
        for (int i = 0; i < 64; i++) w_rom[i] = -8'sd128;
        load_frame(xv, 1'b0);
        wait_complete(1'b0);

        // Shift rounding toward -inf with bias-only accumulators.
        for (int i = 0; i < 64; i++) w_rom[i] = '0;
        b_rom[0] = -16'sd1;   b_rom[1] = 16'sd255;  b_rom[2] = -16'sd129;
        b_rom[3] = 16'sd128;  b_rom[4] = -16'sd128; b_rom[5] = 16'sd127;
        b_rom[6] = 16'sd0;    b_rom[7] = 16'sd1;    b_rom[8] = -16'sd200;
        b_rom[9] = 16'sd300;
        xv = '{5, -3, 100, -128};
        load_frame(xv, 1'b0);
        wait_complete(1'b0);

        for (int c = 0; c < CLASS_NUM; c++) b_rom[c] = -16'sd5;
        load_frame(xv, 1'b0);
        wait_complete(1'b0);

        // Stray input strobes while computing, then a clean frame.
        set_roms_linear();
        xv = '{1, 1, 1, 1};
        load_frame(xv, 1'b0);
        wait_complete(1'b1);
        load_frame(xv, 1'b0);
        wait_complete(1'b0);

        // Mixed-sign random frame.
        for (int i = 0; i < 64; i++) w_rom[i] = 8'($urandom);
        for (int c = 0; c < CLASS_NUM; c++) b_rom[c] = 16'(int'($urandom_range(2000)) - 1000);
        for (int i = 0; i < IN_NUM; i++) xv[i] = int'($urandom_range(255)) - 128;
        load_frame(xv, 1'b1);
        wait_complete(1'b0);

        // Asynchronous reset in the middle of class 3.
        set_roms_linear();
        xv = '{1, 1, 1, 1};
        load_frame(xv, 1'b0);
        for (int i = 0; i < 100 && rcnt < 3; i++) @(negedge clk);
        check("reach_class3", rcnt, 3);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_async_score", int'(l7_0), 0);
        check("rst_async_ready", int'(rdy0), 0);
        check("rst_async_score7", int'(l7_7), 0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        repeat (20) @(negedge clk);
        load_frame(xv, 1'b0);
        wait_complete(1'b0);

        repeat (5) @(negedge clk);
        check("q0_drained", q0.size(), 0);
        check("q7_drained", q7.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
